reg_to_axi_lite_bridge: RTL

- Register-bus to AXI4 master bridge for DMA/peripheral configuration paths; one transaction in flight, single-beat.
- Generalises the existing register-to-AXI adapter: register data narrower than or equal to AXI data with byte-lane steering, misalignment detection, configurable fixed AXI attributes, and an optional response timeout with drain.

---
 rtl/reg_to_axi_lite_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_to_axi_lite_bridge.sv
// reg_to_axi_lite_bridge: register-bus to AXI4 master bridge, one single-beat
// transaction in flight. Register data may be narrower than AXI data; writes
// replicate the data across all lanes and steer the strobes, reads pick the
// lane addressed by the request.
// Build macro REG_TO_AXI_TIMEOUT_EN adds a response timeout plus a DRAIN state
// that swallows the late B/R beat before the next request is accepted.
// Handshake rule (all AXI channels): a beat transfers on a rising edge where
// valid and ready are both high; the valid side holds valid and payload stable
// until that edge and never withdraws valid early.
module reg_to_axi_lite_bridge #(
  parameter int unsigned           FREQ_HZ      = 100000000,
  parameter int unsigned           AxiDataWidth = 64,
  parameter int unsigned           AxiAddrWidth = 64,
  parameter int unsigned           AxiIdWidth   = 1,
  parameter int unsigned           AxiUserWidth = 1,
  parameter int unsigned           RegDataWidth = 32,
  parameter logic [AxiIdWidth-1:0] AxiId        = '0,
  parameter logic [2:0]            AxiProt      = 3'b000,
  parameter int unsigned           TimeoutNs    = 10000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // register request / response
  input  logic [AxiAddrWidth-1:0]     reg_req_addr,
  input  logic                        reg_req_write,
  input  logic [RegDataWidth-1:0]     reg_req_wdata,
  input  logic [RegDataWidth/8-1:0]   reg_req_wstrb,
  input  logic                        reg_req_valid,
  output logic [RegDataWidth-1:0]     reg_rsp_rdata,
  output logic                        reg_rsp_error,
  output logic                        reg_rsp_ready,
  // AW
  output logic [AxiIdWidth-1:0]       axi_req_aw_id,
  output logic [AxiAddrWidth-1:0]     axi_req_aw_addr,
  output logic [7:0]                  axi_req_aw_len,
  output logic [2:0]                  axi_req_aw_size,
  output logic [1:0]                  axi_req_aw_burst,
  output logic                        axi_req_aw_lock,
  output logic [3:0]                  axi_req_aw_cache,
  output logic [2:0]                  axi_req_aw_prot,
  output logic [3:0]                  axi_req_aw_qos,
  output logic [3:0]                  axi_req_aw_region,
  output logic [5:0]                  axi_req_aw_atop,
  output logic [AxiUserWidth-1:0]     axi_req_aw_user,
  output logic                        axi_req_aw_valid,
  input  logic                        axi_rsp_aw_ready,
  // W
  output logic [AxiDataWidth-1:0]     axi_req_w_data,
  output logic [AxiDataWidth/8-1:0]   axi_req_w_strb,
  output logic                        axi_req_w_last,
  output logic [AxiUserWidth-1:0]     axi_req_w_user,
  output logic                        axi_req_w_valid,
  input  logic                        axi_rsp_w_ready,
  // B
  input  logic [AxiIdWidth-1:0]       axi_rsp_b_id,
  input  logic [1:0]                  axi_rsp_b_resp,
  input  logic [AxiUserWidth-1:0]     axi_rsp_b_user,
  input  logic                        axi_rsp_b_valid,
  output logic                        axi_req_b_ready,
  // AR
  output logic [AxiIdWidth-1:0]       axi_req_ar_id,
  output logic [AxiAddrWidth-1:0]     axi_req_ar_addr,
  output logic [7:0]                  axi_req_ar_len,
  output logic [2:0]                  axi_req_ar_size,
  output logic [1:0]                  axi_req_ar_burst,
  output logic                        axi_req_ar_lock,
  output logic [3:0]                  axi_req_ar_cache,
  output logic [2:0]                  axi_req_ar_prot,
  output logic [3:0]                  axi_req_ar_qos,
  output logic [3:0]                  axi_req_ar_region,
  output logic [AxiUserWidth-1:0]     axi_req_ar_user,
  output logic                        axi_req_ar_valid,
  input  logic                        axi_rsp_ar_ready,
  // R
  input  logic [AxiIdWidth-1:0]       axi_rsp_r_id,
  input  logic [AxiDataWidth-1:0]     axi_rsp_r_data,
  input  logic [1:0]                  axi_rsp_r_resp,
  input  logic                        axi_rsp_r_last,
  input  logic [AxiUserWidth-1:0]     axi_rsp_r_user,
  input  logic                        axi_rsp_r_valid,
  output logic                        axi_req_r_ready,
  // debug: current FSM state
  output logic [2:0]                  dbg_state_o
);

  localparam int unsigned RegBytes = RegDataWidth / 8;
  localparam int unsigned AxiBytes = AxiDataWidth / 8;
  localparam int unsigned NumLanes = AxiDataWidth / RegDataWidth;
  localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int unsigned RegOffW  = $clog2(RegBytes);
  localparam int unsigned AxiOffW  = $clog2(AxiBytes);

  // Timeout in clock cycles, never below one cycle.
  localparam logic [63:0] TimeoutRaw    = (64'(TimeoutNs) * 64'(FREQ_HZ)) / 64'd1000000000;
  localparam logic [31:0] TimeoutCycles = (TimeoutRaw == 64'd0) ? 32'd1 : TimeoutRaw[31:0];

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP
`ifdef REG_TO_AXI_TIMEOUT_EN
    , DRAIN
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [AxiAddrWidth-1:0]   addr_q, addr_d;
  logic                      write_q, write_d;
  logic [RegDataWidth-1:0]   wdata_q, wdata_d;
  logic [RegBytes-1:0]       wstrb_q, wstrb_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;
  logic [RegDataWidth-1:0]   rdata_q, rdata_d;
  logic                      error_q, error_d;

`ifdef REG_TO_AXI_TIMEOUT_EN
  logic [31:0]               cnt_q, cnt_d;
  logic                      timed_out_q, timed_out_d;
`endif

  logic [LaneW-1:0]          lane;
  logic [AxiBytes-1:0]       w_strb_steer;
  logic [RegDataWidth-1:0]   r_lane_data;
  logic                      misaligned;
  logic                      unused_inputs;

  // Lane index comes from the address bits between register and AXI width.
  if (NumLanes > 1) begin : g_lane
    assign lane = addr_q[AxiOffW-1:RegOffW];
  end else begin : g_no_lane
    assign lane = '0;
  end

  assign misaligned = (reg_req_addr & AxiAddrWidth'(RegBytes - 1)) != '0;

  // Steer write strobes into the addressed lane and select the read lane.
  always_comb begin
    w_strb_steer = '0;
    r_lane_data  = '0;
    for (int i = 0; i < int'(NumLanes); i++) begin
      if (lane == LaneW'(i)) begin
        w_strb_steer[i*RegBytes +: RegBytes] = wstrb_q;
        r_lane_data = axi_rsp_r_data[i*RegDataWidth +: RegDataWidth];
      end
    end
  end

  // Next-state and datapath update for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
`ifdef REG_TO_AXI_TIMEOUT_EN
    timed_out_d = timed_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reg_req_valid) begin
          addr_d  = reg_req_addr;
          write_d = reg_req_write;
          wdata_d = reg_req_wdata;
          wstrb_d = reg_req_wstrb;
          rdata_d = '0;
          error_d = 1'b0;
`ifdef REG_TO_AXI_TIMEOUT_EN
          timed_out_d = 1'b0;
`endif
          if (misaligned) begin
            // Reject without touching the AXI side.
            error_d = 1'b1;
            state_d = RESP;
          end else if (reg_req_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (aw_pend_q && axi_rsp_aw_ready) aw_pend_d = 1'b0;
        if (w_pend_q && axi_rsp_w_ready)   w_pend_d  = 1'b0;
        if ((!aw_pend_q || axi_rsp_aw_ready) && (!w_pend_q || axi_rsp_w_ready)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (axi_rsp_b_valid) begin
          error_d = axi_rsp_b_resp[1];
          state_d = RESP;
        end
`ifdef REG_TO_AXI_TIMEOUT_EN
        else if (cnt_q == TimeoutCycles - 32'd1) begin
          error_d     = 1'b1;
          rdata_d     = '0;
          timed_out_d = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      READ: begin
        if (axi_rsp_ar_ready) state_d = RDATA;
      end
      RDATA: begin
        if (axi_rsp_r_valid) begin
          error_d = axi_rsp_r_resp[1];
          rdata_d = axi_rsp_r_resp[1] ? '0 : r_lane_data;
          state_d = RESP;
        end
`ifdef REG_TO_AXI_TIMEOUT_EN
        else if (cnt_q == TimeoutCycles - 32'd1) begin
          error_d     = 1'b1;
          rdata_d     = '0;
          timed_out_d = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      RESP: begin
`ifdef REG_TO_AXI_TIMEOUT_EN
        state_d = timed_out_q ? DRAIN : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef REG_TO_AXI_TIMEOUT_EN
      DRAIN: begin
        // Swallow the late response beat of the timed-out transaction.
        if (write_q ? axi_rsp_b_valid : axi_rsp_r_valid) begin
          timed_out_d = 1'b0;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
    end
  end

`ifdef REG_TO_AXI_TIMEOUT_EN
  // Response wait counter: restarts on every state entry, counts while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == WRESP || state_q == RDATA) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Timeout counter and timed-out flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`endif

  // Register response side.
  assign reg_rsp_ready = (state_q == RESP);
  assign reg_rsp_rdata = rdata_q;
  assign reg_rsp_error = error_q;

  // Write address channel.
  assign axi_req_aw_id     = AxiId;
  assign axi_req_aw_addr   = addr_q;
  assign axi_req_aw_len    = 8'd0;
  assign axi_req_aw_size   = 3'(RegOffW);
  assign axi_req_aw_burst  = 2'b01;
  assign axi_req_aw_lock   = 1'b0;
  assign axi_req_aw_cache  = 4'd0;
  assign axi_req_aw_prot   = AxiProt;
  assign axi_req_aw_qos    = 4'd0;
  assign axi_req_aw_region = 4'd0;
  assign axi_req_aw_atop   = 6'd0;
  assign axi_req_aw_user   = '0;
  assign axi_req_aw_valid  = (state_q == WRITE) && aw_pend_q;

  // Write data channel.
  assign axi_req_w_data  = {NumLanes{wdata_q}};
  assign axi_req_w_strb  = w_strb_steer;
  assign axi_req_w_last  = 1'b1;
  assign axi_req_w_user  = '0;
  assign axi_req_w_valid = (state_q == WRITE) && w_pend_q;

  // Read address channel.
  assign axi_req_ar_id     = AxiId;
  assign axi_req_ar_addr   = addr_q;
  assign axi_req_ar_len    = 8'd0;
  assign axi_req_ar_size   = 3'(RegOffW);
  assign axi_req_ar_burst  = 2'b01;
  assign axi_req_ar_lock   = 1'b0;
  assign axi_req_ar_cache  = 4'd0;
  assign axi_req_ar_prot   = AxiProt;
  assign axi_req_ar_qos    = 4'd0;
  assign axi_req_ar_region = 4'd0;
  assign axi_req_ar_user   = '0;
  assign axi_req_ar_valid  = (state_q == READ);

  // Response ready: while waiting, and while draining a late beat.
`ifdef REG_TO_AXI_TIMEOUT_EN
  assign axi_req_b_ready = (state_q == WRESP) || ((state_q == DRAIN) && write_q);
  assign axi_req_r_ready = (state_q == RDATA) || ((state_q == DRAIN) && !write_q);
`else
  assign axi_req_b_ready = (state_q == WRESP);
  assign axi_req_r_ready = (state_q == RDATA);
`endif

  assign dbg_state_o = state_q;

  // IDs, user bits and R last carry no information for a single-beat master.
  assign unused_inputs = ^{axi_rsp_b_id, axi_rsp_b_user, axi_rsp_b_resp[0],
                           axi_rsp_r_id, axi_rsp_r_user, axi_rsp_r_resp[0],
                           axi_rsp_r_last, TimeoutCycles[0]};

endmodule
